// File: rtl/fpu_mul_arb16_if.sv
// ============================================================================
// Module      : fpu_mul_arb16_if
// Description : Request, multiplier and response signal bundle for the
//               fp16 multiplier arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fpu_mul_arb16_if #(
  parameter int NREQ  = 4,
  parameter int FLAGW = 5
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    reqValid;
  logic [NREQ*16-1:0] reqOp1;
  logic [NREQ*16-1:0] reqOp2;
  logic [NREQ-1:0]    reqReady;

  logic [15:0]        mulIn1;
  logic [15:0]        mulIn2;
  logic               mulStart;
  logic               mulReset;
  logic [15:0]        mulOut;
  logic               mulDone;
  logic [3:0]         mulCond;
  logic [FLAGW-1:0]   mulFlags;

  logic               rspValid;
  logic               rspReady;
  logic [IDW-1:0]     rspId;
  logic [15:0]        rspResult;
  logic [3:0]         rspCond;
  logic [FLAGW-1:0]   rspFlags;
  logic               rspErr;

  modport slave (
    input  reqValid, reqOp1, reqOp2,
    output reqReady,
    output mulIn1, mulIn2, mulStart, mulReset,
    input  mulOut, mulDone, mulCond, mulFlags,
    output rspValid, rspId, rspResult, rspCond, rspFlags, rspErr,
    input  rspReady
  );

  modport master (
    output reqValid, reqOp1, reqOp2,
    input  reqReady,
    input  mulIn1, mulIn2, mulStart, mulReset,
    output mulOut, mulDone, mulCond, mulFlags,
    input  rspValid, rspId, rspResult, rspCond, rspFlags, rspErr,
    output rspReady
  );
endinterface

`default_nettype wire

// File: rtl/fpu_mul_arb16.sv
// ============================================================================
// Module      : fpu_mul_arb16
// Description : Round-robin arbiter sharing one fp16 multiplier among NREQ
//               requesters. Optional macro FPU_MUL_ARB_TIMEOUT_EN adds a
//               BUSY watchdog that returns a NaN error response.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fpu_mul_arb16 #(
  parameter int NREQ    = 4,
  parameter int FLAGW   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  fpu_mul_arb16_if.slave   bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    START = 3'd2,
    BUSY  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   op_id;
  logic             grant_any;
  logic [IDW:0]     rr_sum;
  logic [IDW-1:0]   rr_cand;
  logic [NREQ-1:0]  ready;
  logic [15:0]      grant_op1;
  logic [15:0]      grant_op2;
  logic [15:0]      op1;
  logic [15:0]      op2;
  logic [15:0]      rsp_result;
  logic [3:0]       rsp_cond;
  logic [FLAGW-1:0] rsp_flags;
  logic             rsp_err;
  logic             timeout_hit;
  logic             accept;
  logic             done_ok;

  // Round-robin search starting one past the previous winner, wrapping at NREQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    rr_sum    = '0;
    rr_cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_sum = {1'b0, last_grant} + (IDW+1)'(k);
      if (rr_sum >= (IDW+1)'(NREQ)) begin
        rr_sum = rr_sum - (IDW+1)'(NREQ);
      end
      rr_cand = rr_sum[IDW-1:0];
      if (!grant_any && bus.reqValid[rr_cand]) begin
        grant_any = 1'b1;
        grant_idx = rr_cand;
      end
    end
  end

  always_comb begin
    grant_op1 = '0;
    grant_op2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        grant_op1 = bus.reqOp1[16*i +: 16];
        grant_op2 = bus.reqOp2[16*i +: 16];
      end
    end
  end

  assign accept  = (state == IDLE) && grant_any;
  assign done_ok = (state == BUSY) && bus.mulDone;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ready    = '0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          ready[grant_idx] = 1'b1;
          state_nx         = CLEAR;
        end
      end
      CLEAR:   state_nx = START;
      START:   state_nx = BUSY;
      BUSY: begin
        if (bus.mulDone || timeout_hit) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        if (bus.rspReady) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= IDW'(NREQ-1);
      op_id      <= '0;
      op1        <= '0;
      op2        <= '0;
      rsp_result <= '0;
      rsp_cond   <= '0;
      rsp_flags  <= '0;
    end else begin
      if (accept) begin
        last_grant <= grant_idx;
        op_id      <= grant_idx;
        op1        <= grant_op1;
        op2        <= grant_op2;
      end
      if (done_ok) begin
        rsp_result <= bus.mulOut;
        rsp_cond   <= bus.mulCond;
        rsp_flags  <= bus.mulFlags;
      end else if (timeout_hit) begin
        rsp_result <= 16'h7E00;
        rsp_cond   <= '0;
        rsp_flags  <= '0;
      end
    end
  end

`ifdef FPU_MUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] busy_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_cnt <= '0;
    end else if (state != BUSY) begin
      busy_cnt <= '0;
    end else begin
      busy_cnt <= busy_cnt + CW'(1);
    end
  end

  // Fires in the last of TIMEOUT consecutive BUSY cycles without done.
  assign timeout_hit = (state == BUSY) && !bus.mulDone && (busy_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_err <= 1'b0;
    end else if (done_ok) begin
      rsp_err <= 1'b0;
    end else if (timeout_hit) begin
      rsp_err <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
  assign unused_cfg  = (TIMEOUT > 0);
`endif

  // Local restart also follows the block reset so an aborted op is cleared.
  assign bus.mulReset  = reset | (state == CLEAR);
  assign bus.mulStart  = (state == START);
  assign bus.mulIn1    = op1;
  assign bus.mulIn2    = op2;
  assign bus.reqReady  = ready;
  assign bus.rspValid  = (state == RESP);
  assign bus.rspId     = op_id;
  assign bus.rspResult = rsp_result;
  assign bus.rspCond   = rsp_cond;
  assign bus.rspFlags  = rsp_flags;
  assign bus.rspErr    = rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_fpu_mul_arb16.sv
// ============================================================================
// Module      : tb_fpu_mul_arb16
// Description : Directed table-driven bench for fpu_mul_arb16 with a
//               behavioural sticky-done multiplier stub.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fpu_mul_arb16;
  localparam int NREQ    = 4;
  localparam int FLAGW   = 5;
  localparam int TIMEOUT = 64;

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    logic [3:0]  cond;
    logic [4:0]  flags;
    logic [15:0] exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fpu_mul_arb16_if #(.NREQ(NREQ), .FLAGW(FLAGW)) bus ();

  fpu_mul_arb16 #(.NREQ(NREQ), .FLAGW(FLAGW), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Multiplier stub: result looked up from operands, done sticky until mulReset.
  int          mul_lat  = 1;
  bit          mul_hang = 1'b0;
  logic [3:0]  stub_cond  = '0;
  logic [4:0]  stub_flags = '0;
  logic [15:0] stub_out   = '0;
  logic        stub_done  = 1'b0;
  bit          stub_busy  = 1'b0;
  int          stub_cnt   = 0;
  int          n_clr   = 0;
  int          n_start = 0;

  function automatic logic [15:0] fp16_ref(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] key;
    key = {a, b};
    case (key)
      32'h3C00_3C00: return 16'h3C00;
      32'h4000_4200: return 16'h4600;
      32'h4000_4000: return 16'h4400;
      32'h3800_4000: return 16'h3C00;
      32'hC000_4000: return 16'hC400;
      default:       return 16'hDEAD;
    endcase
  endfunction

  always @(posedge clock) begin
    if (bus.mulReset) begin
      stub_done <= 1'b0;
      stub_busy <= 1'b0;
    end else if (bus.mulStart) begin
      stub_out <= fp16_ref(bus.mulIn1, bus.mulIn2);
      if (mul_hang) begin
        stub_busy <= 1'b0;
      end else if (mul_lat <= 1) begin
        stub_done <= 1'b1;
      end else begin
        stub_busy <= 1'b1;
        stub_cnt  <= mul_lat - 1;
      end
    end else if (stub_busy) begin
      if (stub_cnt == 1) begin
        stub_done <= 1'b1;
        stub_busy <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  always @(posedge clock) begin
    if (!reset) begin
      if (bus.mulReset) n_clr   = n_clr + 1;
      if (bus.mulStart) n_start = n_start + 1;
    end
  end

  assign bus.mulOut   = stub_out;
  assign bus.mulDone  = stub_done;
  assign bus.mulCond  = stub_cond;
  assign bus.mulFlags = stub_flags;

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill_slots();
    bus.reqOp1 = {NREQ{16'hFFFF}};
    bus.reqOp2 = {NREQ{16'hFFFF}};
  endtask

  task automatic run_op(input vec_t v, input bit hold5);
    int cyc;
    logic [15:0] held;
    step();
    fill_slots();
    bus.reqOp1[16*v.id +: 16] = v.a;
    bus.reqOp2[16*v.id +: 16] = v.b;
    stub_cond  = v.cond;
    stub_flags = v.flags;
    mul_lat    = v.lat;
    n_clr      = 0;
    n_start    = 0;
    bus.reqValid = NREQ'(1) << v.id;
    #1;
    cyc = 0;
    while (bus.reqReady[v.id] !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    check("grant", 32'(bus.reqReady), 32'(NREQ'(1) << v.id));
    step();
    bus.reqValid = '0;
    cyc = 1;
    while (bus.rspValid !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    check("latency", 32'(cyc), 32'(3 + v.lat));
    check("rspResult", 32'(bus.rspResult), 32'(v.exp));
    check("rspId", 32'(bus.rspId), 32'(v.id));
    check("rspCond", 32'(bus.rspCond), 32'(v.cond));
    check("rspFlags", 32'(bus.rspFlags), 32'(v.flags));
    check("rspErr", 32'(bus.rspErr), 32'(0));
    check("clr_pulses", 32'(n_clr), 32'(1));
    check("start_pulses", 32'(n_start), 32'(1));
    if (hold5) begin
      held = bus.rspResult;
      bus.reqValid = '1;
      for (int k = 0; k < 5; k++) begin
        step();
        check("bp_valid", 32'(bus.rspValid), 32'(1));
        check("bp_result", 32'(bus.rspResult), 32'(held));
        check("bp_ready", 32'(bus.reqReady), 32'(0));
      end
      bus.reqValid = '0;
    end
    bus.rspReady = 1'b1;
    step();
    bus.rspReady = 1'b0;
    check("post_hs_valid", 32'(bus.rspValid), 32'(0));
  endtask

  vec_t vt[5];
  int   grants[$];
  int   cyc;

  initial begin
    vt[0] = '{id: 0, a: 16'h3C00, b: 16'h3C00, lat: 1, cond: 4'h0, flags: 5'h00, exp: 16'h3C00};
    vt[1] = '{id: 2, a: 16'h4000, b: 16'h4200, lat: 3, cond: 4'h0, flags: 5'h01, exp: 16'h4600};
    vt[2] = '{id: 1, a: 16'h4000, b: 16'h4000, lat: 2, cond: 4'h1, flags: 5'h04, exp: 16'h4400};
    vt[3] = '{id: 3, a: 16'h3800, b: 16'h4000, lat: 5, cond: 4'h8, flags: 5'h10, exp: 16'h3C00};
    vt[4] = '{id: 2, a: 16'hC000, b: 16'h4000, lat: 1, cond: 4'h2, flags: 5'h03, exp: 16'hC400};

    bus.reqValid = '0;
    bus.rspReady = 1'b0;
    fill_slots();
    reset = 1'b1;
    step();
    step();
    check("rst_mulReset", 32'(bus.mulReset), 32'(1));
    check("rst_mulStart", 32'(bus.mulStart), 32'(0));
    check("rst_rspValid", 32'(bus.rspValid), 32'(0));
    check("rst_rspResult", 32'(bus.rspResult), 32'(0));
    check("rst_rspId", 32'(bus.rspId), 32'(0));
    check("rst_rspErr", 32'(bus.rspErr), 32'(0));
    reset = 1'b0;
    step();
    check("idle_mulReset", 32'(bus.mulReset), 32'(0));

    for (int i = 0; i < 5; i++) begin
      run_op(vt[i], (i == 3));
    end

    // Reset in the middle of BUSY: no response, pointer restored.
    mul_hang = 1'b1;
    fill_slots();
    bus.reqOp1[16 +: 16] = 16'h4000;
    bus.reqOp2[16 +: 16] = 16'h4000;
    bus.reqValid = 4'b0010;
    #1;
    cyc = 0;
    while (bus.reqReady !== 4'b0010 && cyc < 20) begin
      step();
      cyc++;
    end
    check("abort_grant", 32'(bus.reqReady), 32'(4'b0010));
    step();
    bus.reqValid = '0;
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    check("abort_mulReset", 32'(bus.mulReset), 32'(1));
    check("abort_rspResult", 32'(bus.rspResult), 32'(0));
    step();
    reset = 1'b0;
    mul_hang = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("abort_no_rsp", 32'(bus.rspValid), 32'(0));
    end
    bus.reqOp1[0 +: 16] = 16'h3C00;
    bus.reqOp2[0 +: 16] = 16'h3C00;
    mul_lat = 2;
    bus.reqValid = '1;
    #1;
    check("abort_next_grant", 32'(bus.reqReady), 32'(4'b0001));
    step();
    bus.reqValid = '0;
    cyc = 0;
    while (bus.rspValid !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    check("abort_next_rsp", 32'(bus.rspResult), 32'(16'h3C00));
    bus.rspReady = 1'b1;
    step();
    bus.rspReady = 1'b0;

    // Round-robin order with every requester asserting.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    mul_lat = 1;
    bus.reqOp1 = {NREQ{16'h3C00}};
    bus.reqOp2 = {NREQ{16'h3C00}};
    bus.rspReady = 1'b1;
    bus.reqValid = '1;
    #1;
    cyc = 0;
    while (grants.size() < 5 && cyc < 200) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.reqReady[i] === 1'b1) grants.push_back(i);
      end
      step();
      cyc++;
    end
    bus.reqValid = '0;
    bus.rspReady = 1'b0;
    check("rr_count", 32'(grants.size()), 32'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < grants.size()) check("rr_order", 32'(grants[i]), 32'(i % NREQ));
    end
    cyc = 0;
    while (bus.rspValid === 1'b1 && cyc < 20) begin
      bus.rspReady = 1'b1;
      step();
      cyc++;
    end
    bus.rspReady = 1'b0;
    step();

`ifdef FPU_MUL_ARB_TIMEOUT_EN
    mul_hang = 1'b1;
    bus.reqValid = 4'b1000;
    #1;
    cyc = 0;
    while (bus.reqReady !== 4'b1000 && cyc < 20) begin
      step();
      cyc++;
    end
    check("to_grant", 32'(bus.reqReady), 32'(4'b1000));
    step();
    bus.reqValid = '0;
    cyc = 1;
    while (bus.rspValid !== 1'b1 && cyc < 300) begin
      step();
      cyc++;
    end
    check("to_latency", 32'(cyc), 32'(3 + TIMEOUT));
    check("to_rspErr", 32'(bus.rspErr), 32'(1));
    check("to_rspResult", 32'(bus.rspResult), 32'(16'h7E00));
    check("to_rspCond", 32'(bus.rspCond), 32'(0));
    check("to_rspFlags", 32'(bus.rspFlags), 32'(0));
    bus.rspReady = 1'b1;
    step();
    bus.rspReady = 1'b0;
    mul_hang = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/fpu_mul_arb16.md
FPU_MUL_ARB16 -- requirements
Module: fpu_mul_arb16

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of requesters sharing one fp16 multiplier (2..8).
REQ-002 The block SHALL have parameter FLAGW, default 5: width of the multiplier op-status flag bus.
REQ-003 The block SHALL have parameter TIMEOUT, default 64: watchdog limit in cycles.
REQ-004 The block SHALL have port clock  in  1  sole clock, rising edge.
REQ-005 The block SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port reqValid  in  NREQ  per-requester operation request.
REQ-007 The block SHALL have ports reqOp1, reqOp2  in  NREQ*16 each  packed fp16 operands; requester i uses bits [16i+15:16i].
REQ-008 The block SHALL have port reqReady  out  NREQ  one-hot grant; request i is accepted in the cycle in which reqValid[i] and reqReady[i] are both high.
REQ-009 The block SHALL have ports mulIn1, mulIn2  out  16 each  operands to the multiplier.
REQ-010 The block SHALL have ports mulStart, mulReset  out  1 each  multiplier start and local restart.
REQ-011 The block SHALL have ports mulOut  in  16, mulDone  in  1, mulCond  in  4, mulFlags  in  FLAGW: multiplier result, done, ZCNV codes and status flags.
REQ-012 The block SHALL have ports rspValid  out  1, rspReady  in  1, rspId  out  $clog2(NREQ), rspResult  out  16, rspCond  out  4, rspFlags  out  FLAGW, rspErr  out  1.

Function
REQ-013 The FSM SHALL have five states: IDLE, CLEAR, START, BUSY and RESP.
REQ-014 In IDLE, when any reqValid bit is set, exactly one reqReady bit SHALL be asserted combinationally; the block SHALL latch that requester's operands and id, then go to CLEAR.
REQ-015 Arbitration SHALL be round-robin: search starts at lastGrant+1 mod NREQ; lastGrant updates on each grant.
REQ-016 reqReady SHALL be all-zero in every state except IDLE.
REQ-017 In CLEAR, mulReset SHALL be 1 for exactly one cycle; then the FSM SHALL go to START. This restarts a multiplier whose done state is sticky.
REQ-018 In START, mulStart SHALL be 1 for exactly one cycle; then the FSM SHALL go to BUSY.
REQ-019 mulIn1 and mulIn2 SHALL equal the latched operands, stable from CLEAR through the cycle in which mulDone is sampled.
REQ-020 In BUSY, on mulDone=1 the block SHALL capture mulOut, mulCond and mulFlags into the rsp* registers, set rspErr=0, and go to RESP.
REQ-021 In RESP, rspValid SHALL be 1 and all rsp* outputs SHALL be held; on rspReady=1 the FSM SHALL go to IDLE.
REQ-022 Back-pressure: with rspReady=0 the block SHALL stay in RESP indefinitely and grant nothing.
REQ-023 Minimum latency SHALL be: grant in cycle 0, rspValid in cycle 3+M, where M is the number of BUSY cycles until mulDone.
REQ-024 A new grant SHALL be allowed in the cycle after a RESP handshake; the arbiter has no same-cycle bypass.
REQ-025 A reqValid deasserted before its grant SHALL be ignored, with no state change.
REQ-026 mulDone sampled in any state other than BUSY SHALL be ignored.

Reset
REQ-027 While reset=1, the FSM SHALL be in IDLE, lastGrant=NREQ-1, and rspValid=0, rspErr=0, rspResult=0, rspCond=0, rspFlags=0, rspId=0, mulStart=0.
REQ-028 mulReset SHALL be asserted whenever reset=1, including reset asserted mid-operation.
REQ-029 An in-flight operation aborted by reset SHALL produce no response.

Configuration
REQ-030 With macro FPU_MUL_ARB_TIMEOUT_EN defined, a counter SHALL run in BUSY; if TIMEOUT cycles pass without mulDone, the block SHALL enter RESP with rspErr=1, rspResult=16'h7E00, rspCond=0 and rspFlags=0.
REQ-031 Without FPU_MUL_ARB_TIMEOUT_EN, no counter SHALL exist, BUSY SHALL wait unbounded, and rspErr SHALL be tied to 0.

Verification
REQ-032 Requester 0 sends 3C00 x 3C00 -> rspResult=3C00, rspId=0, rspErr=0, with exactly one mulReset pulse and one mulStart pulse.
REQ-033 Requester 2 sends 4000 x 4200 -> rspResult=4600, rspId=2.
REQ-034 All four reqValid held high after reset, rspReady=1 -> grant order 0,1,2,3,0.
REQ-035 rspReady=0 for 5 cycles in RESP -> rspValid and rspResult stable, reqReady=0 throughout.
REQ-036 reset pulsed while in BUSY -> rspValid=0, IDLE, lastGrant=NREQ-1, and the next grant goes to requester 0.
REQ-037 With TIMEOUT_EN and mulDone tied to 0 -> rspValid after 64 BUSY cycles, rspErr=1, rspResult=7E00.
